// File: rtl/stack_pkg.sv
// Shared encodings for the stack controller: request opcodes, RAM delta codes
// and controller states.
package stack_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_REPL = 2'b11
    } op_e;

    localparam logic [1:0] DELTA_HOLD = 2'b00;
    localparam logic [1:0] DELTA_INC  = 2'b01;
    localparam logic [1:0] DELTA_DEC  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

endpackage

// File: rtl/stack_depth_cnt.sv
// Saturating stack depth counter with full/empty decode.
// Optional high-water mark output when STACK_CTRL_HWM_EN is defined.
module stack_depth_cnt #(
    parameter int DEPTH   = 512,
    parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               dec,
    input  logic               clr_hwm,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
`ifdef STACK_CTRL_HWM_EN
    ,
    output logic [DEPTH_W-1:0] hwm
`endif
);

    localparam logic [DEPTH_W-1:0] MAX = DEPTH_W'(DEPTH);
    localparam logic [DEPTH_W-1:0] ONE = DEPTH_W'(1);

    logic [DEPTH_W-1:0] count;
    logic               grow;

    assign grow  = inc && (count != MAX);
    assign depth = count;
    assign full  = (count == MAX);
    assign empty = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (grow) begin
            count <= count + ONE;
        end else if (dec && (count != '0)) begin
            count <= count - ONE;
        end
    end

`ifdef STACK_CTRL_HWM_EN
    // The mark only moves on an actual increase, so a clear sticks until the next push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwm <= '0;
        end else if (clr_hwm) begin
            hwm <= '0;
        end else if (grow && ((count + ONE) > hwm)) begin
            hwm <= count + ONE;
        end
    end
`else
    logic unused_clr;
    assign unused_clr = clr_hwm;
`endif

endmodule

// File: rtl/stack_ctrl.sv
// Stack RAM initiator: TOS held in a register, lower cells in an external RAM.
// Define STACK_CTRL_HWM_EN to add the depth high-water-mark output hwm.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 512,
    parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [WIDTH-1:0]   req_data,
    output logic [WIDTH-1:0]   tos,
    output logic [DEPTH_W-1:0] depth,
    output logic               empty,
    output logic               full,
    output logic               err_ovf,
    output logic               err_unf,
    input  logic               err_clr,
    output logic               ram_we,
    output logic [1:0]         ram_delta,
    output logic [WIDTH-1:0]   ram_wd,
    input  logic [WIDTH-1:0]   ram_rd
`ifdef STACK_CTRL_HWM_EN
    ,
    output logic [DEPTH_W-1:0] hwm
`endif
);

    localparam logic [DEPTH_W-1:0] ONE = DEPTH_W'(1);

    state_e           state;
    state_e           next_state;
    logic [WIDTH-1:0] tos_next;
    logic             accept;
    logic             inc;
    logic             dec;
    logic             set_ovf;
    logic             set_unf;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    stack_depth_cnt #(
        .DEPTH   (DEPTH),
        .DEPTH_W (DEPTH_W)
    ) u_depth (
        .clk     (clk),
        .rst     (rst),
        .inc     (inc),
        .dec     (dec),
        .clr_hwm (err_clr),
        .depth   (depth),
        .full    (full),
        .empty   (empty)
`ifdef STACK_CTRL_HWM_EN
        ,
        .hwm     (hwm)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tos     <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            state   <= next_state;
            tos     <= tos_next;
            err_ovf <= !err_clr && (err_ovf || set_ovf);
            err_unf <= !err_clr && (err_unf || set_unf);
        end
    end

    always_comb begin
        next_state = state;
        tos_next   = tos;
        inc        = 1'b0;
        dec        = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        ram_we     = 1'b0;
        ram_delta  = DELTA_HOLD;
        ram_wd     = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (op_e'(req_op))
                        OP_PUSH: begin
                            if (full) begin
                                set_ovf = 1'b1;
                            end else begin
                                inc      = 1'b1;
                                tos_next = req_data;
                                // An empty stack has no old TOS worth spilling.
                                if (!empty) begin
                                    ram_we    = 1'b1;
                                    ram_delta = DELTA_INC;
                                    ram_wd    = tos;
                                end
                            end
                        end
                        OP_POP: begin
                            if (empty) begin
                                set_unf = 1'b1;
                            end else if (depth == ONE) begin
                                dec      = 1'b1;
                                tos_next = '0;
                            end else begin
                                dec        = 1'b1;
                                ram_delta  = DELTA_DEC;
                                next_state = FILL;
                            end
                        end
                        OP_REPL: begin
                            tos_next = req_data;
                            inc      = empty;
                        end
                        default: ;
                    endcase
                end
            end
            FILL: begin
                // RAM read data for the popped cell arrives one cycle after the delta.
                tos_next   = ram_rd;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl (DEPTH=8): directed table, corner sequences and random ops
// against a queue-based stack model with a behavioural stack RAM.
module tb_stack_ctrl;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int DW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [W-1:0]  req_data = '0;
    logic [W-1:0]  tos;
    logic [DW-1:0] depth;
    logic          empty, full, err_ovf, err_unf;
    logic          err_clr = 1'b0;
    logic          ram_we;
    logic [1:0]    ram_delta;
    logic [W-1:0]  ram_wd;
    logic [W-1:0]  ram_rd;
`ifdef STACK_CTRL_HWM_EN
    logic [DW-1:0] hwm;
`endif

    stack_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .tos       (tos),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf),
        .err_clr   (err_clr),
        .ram_we    (ram_we),
        .ram_delta (ram_delta),
        .ram_wd    (ram_wd),
        .ram_rd    (ram_rd)
`ifdef STACK_CTRL_HWM_EN
        ,
        .hwm       (hwm)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural stack RAM: pointer moves by delta, write lands in the new top cell,
    // read data of the popped cell is registered.
    logic [W-1:0] mem [0:15];
    int           sp;
    logic [W-1:0] rd_q;
    assign ram_rd = rd_q;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp   <= 0;
            rd_q <= '0;
        end else if (ram_delta == 2'b01) begin
            sp <= sp + 1;
        end else if (ram_delta == 2'b11) begin
            rd_q <= mem[sp[3:0]];
            sp   <= sp - 1;
        end
    end

    always @(posedge clk) begin
        if (!rst && ram_delta == 2'b01 && ram_we) mem[4'(sp + 1)] <= ram_wd;
    end

    // Reference model
    logic [W-1:0] q[$];
    bit           m_ovf, m_unf;
    int           m_hwm;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 0;
        m_unf = 0;
        m_hwm = 0;
    endtask

    task automatic chk_state();
        logic [W-1:0] mtos;
        mtos = (q.size() != 0) ? q[q.size()-1] : '0;
        chk("tos",   32'(tos),     32'(mtos));
        chk("depth", 32'(depth),   32'(q.size()));
        chk("empty", 32'(empty),   32'(q.size() == 0));
        chk("full",  32'(full),    32'(q.size() == D));
        chk("ovf",   32'(err_ovf), 32'(m_ovf));
        chk("unf",   32'(err_unf), 32'(m_unf));
`ifdef STACK_CTRL_HWM_EN
        chk("hwm",   32'(hwm),     32'(m_hwm));
`endif
    endtask

    // Called just after a falling edge; returns just after the falling edge that
    // follows completion (including a FILL cycle for a RAM-backed pop).
    task automatic do_op(input logic v, input logic [1:0] op, input logic [W-1:0] d,
                         input logic clr);
        int           n;
        logic [W-1:0] top;
        logic         e_we;
        logic [1:0]   e_dl;
        logic [W-1:0] e_wd;
        bit           fill, grew, s_ovf, s_unf;
        n    = q.size();
        top  = (n != 0) ? q[n-1] : '0;
        e_we = 1'b0;
        e_dl = 2'b00;
        e_wd = '0;
        fill = 0;
        chk("ready_idle", 32'(req_ready), 32'd1);
        req_valid = v;
        req_op    = op;
        req_data  = d;
        err_clr   = clr;
        #1;
        if (v) begin
            if (op == 2'b01 && n < D && n >= 1) begin
                e_we = 1'b1;
                e_dl = 2'b01;
                e_wd = top;
            end
            if (op == 2'b10 && n >= 2) begin
                e_dl = 2'b11;
                fill = 1;
            end
        end
        chk("ram_we",    32'(ram_we),    32'(e_we));
        chk("ram_delta", 32'(ram_delta), 32'(e_dl));
        if (e_we) chk("ram_wd", 32'(ram_wd), 32'(e_wd));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        err_clr   = 1'b0;
        grew  = 0;
        s_ovf = 0;
        s_unf = 0;
        if (v) begin
            case (op)
                2'b01: if (n == D) s_ovf = 1; else begin q.push_back(d); grew = 1; end
                2'b10: if (n == 0) s_unf = 1; else void'(q.pop_back());
                2'b11: if (n == 0) begin q.push_back(d); grew = 1; end else q[n-1] = d;
                default: ;
            endcase
        end
        if (clr) begin
            m_ovf = 0;
            m_unf = 0;
            m_hwm = 0;
        end else begin
            m_ovf = m_ovf | s_ovf;
            m_unf = m_unf | s_unf;
            if (grew && q.size() > m_hwm) m_hwm = q.size();
        end
        if (fill) begin
            @(negedge clk);
            chk("ready_fill", 32'(req_ready), 32'd0);
            chk("delta_fill", 32'(ram_delta), 32'd0);
        end
        @(negedge clk);
        chk_state();
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] data;
        logic         clr;
        logic [W-1:0] e_tos;
        int           e_depth;
        logic         e_unf;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{2'b01, 16'h1111, 1'b0, 16'h1111, 1, 1'b0};
        vecs[1]  = '{2'b01, 16'h2222, 1'b0, 16'h2222, 2, 1'b0};
        vecs[2]  = '{2'b01, 16'h3333, 1'b0, 16'h3333, 3, 1'b0};
        vecs[3]  = '{2'b10, 16'h0000, 1'b0, 16'h2222, 2, 1'b0};
        vecs[4]  = '{2'b10, 16'h0000, 1'b0, 16'h1111, 1, 1'b0};
        vecs[5]  = '{2'b10, 16'h0000, 1'b0, 16'h0000, 0, 1'b0};
        vecs[6]  = '{2'b10, 16'h0000, 1'b0, 16'h0000, 0, 1'b1};
        vecs[7]  = '{2'b00, 16'h0000, 1'b1, 16'h0000, 0, 1'b0};
        vecs[8]  = '{2'b01, 16'h00A1, 1'b0, 16'h00A1, 1, 1'b0};
        vecs[9]  = '{2'b01, 16'h00A2, 1'b0, 16'h00A2, 2, 1'b0};
        vecs[10] = '{2'b11, 16'hBEEF, 1'b0, 16'hBEEF, 2, 1'b0};
        vecs[11] = '{2'b10, 16'h0000, 1'b0, 16'h00A1, 1, 1'b0};
        vecs[12] = '{2'b10, 16'h0000, 1'b0, 16'h0000, 0, 1'b0};
        vecs[13] = '{2'b11, 16'h5555, 1'b0, 16'h5555, 1, 1'b0};
        vecs[14] = '{2'b10, 16'h0000, 1'b0, 16'h0000, 0, 1'b0};

        model_reset();
        #1;
        chk("rst_tos",   32'(tos),       32'd0);
        chk("rst_depth", 32'(depth),     32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_we",    32'(ram_we),    32'd0);
        chk("rst_delta", 32'(ram_delta), 32'd0);
        chk("rst_ovf",   32'(err_ovf),   32'd0);
        chk("rst_unf",   32'(err_unf),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 15; i++) begin
            do_op(1'b1, vecs[i].op, vecs[i].data, vecs[i].clr);
            chk($sformatf("tbl%0d_tos", i),   32'(tos),     32'(vecs[i].e_tos));
            chk($sformatf("tbl%0d_depth", i), 32'(depth),   32'(vecs[i].e_depth));
            chk($sformatf("tbl%0d_unf", i),   32'(err_unf), 32'(vecs[i].e_unf));
        end

        // Fill to capacity, then overflow
        for (int i = 0; i < D; i++) do_op(1'b1, 2'b01, 16'(16'hC000 + i), 1'b0);
        chk("cap_full", 32'(full), 32'd1);
        do_op(1'b1, 2'b01, 16'hDEAD, 1'b0);
        chk("ovf_set",  32'(err_ovf), 32'd1);
        chk("ovf_tos",  32'(tos),     32'h0000C007);
        // Overflow and clear in the same cycle: clear wins
        do_op(1'b1, 2'b01, 16'hDEAD, 1'b1);
        chk("ovf_clr_prio", 32'(err_ovf), 32'd0);
        // Drain, checking each refilled TOS
        for (int i = D - 1; i > 0; i--) begin
            do_op(1'b1, 2'b10, 16'h0000, 1'b0);
            chk("drain_tos", 32'(tos), 32'(16'hC000 + i - 1));
        end
        do_op(1'b1, 2'b10, 16'h0000, 1'b0);
        chk("drain_empty", 32'(empty), 32'd1);

        // Reset asserted during FILL
        do_op(1'b1, 2'b01, 16'h0123, 1'b0);
        do_op(1'b1, 2'b01, 16'h0456, 1'b0);
        req_valid = 1'b1;
        req_op    = 2'b10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        @(negedge clk);
        chk("fill_ready", 32'(req_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rfill_tos",   32'(tos),       32'd0);
        chk("rfill_depth", 32'(depth),     32'd0);
        chk("rfill_ready", 32'(req_ready), 32'd0);
`ifdef STACK_CTRL_HWM_EN
        chk("rfill_hwm",   32'(hwm),       32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_ready", 32'(req_ready), 32'd1);

        // Random operations against the model
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [1:0] op;
            r  = $urandom_range(0, 9);
            op = (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : (r < 8) ? 2'b11 : 2'b00;
            do_op(($urandom_range(0, 7) != 0), op, 16'($urandom),
                  ($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
